// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding and PC step.
package fetch_unit_pkg;

  // PRIME fills the one-cycle ROM pipeline, RUN fetches, HALT parks until reset.
  typedef enum logic [1:0] {
    ST_PRIME = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_e;

  // Byte distance between consecutive instruction words.
  localparam int unsigned PC_STEP = 32'd4;

endpackage : fetch_unit_pkg

// File: rtl/fetch_unit_next_pc_sel.sv
// Next fetch address: redirect target computation and priority selection
// (halt > jr > jump > branch > sequential) for an accepted instruction.
module next_pc_sel
  import fetch_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             accept,
  input  logic             halt,
  input  logic             jr,
  input  logic             jump,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] id_pc,
  input  logic [WIDTH-1:0] jr_target,
  input  logic [15:0]      branch_off,
  input  logic [25:0]      jump_index,
  output logic [WIDTH-1:0] next_pc,
  output logic             redirect
);

  logic [WIDTH-1:0] seq_pc_s;
  logic [WIDTH-1:0] id_pc_plus4_s;
  logic [WIDTH-1:0] branch_target_s;
  logic [WIDTH-1:0] jump_target_s;
  logic [WIDTH-1:0] jr_target_s;

  // Candidate targets; all arithmetic wraps modulo 2^WIDTH.
  assign seq_pc_s        = pc + WIDTH'(PC_STEP);
  assign id_pc_plus4_s   = id_pc + WIDTH'(PC_STEP);
  assign branch_target_s = id_pc_plus4_s + {{(WIDTH-18){branch_off[15]}}, branch_off, 2'b00};
  assign jump_target_s   = {id_pc_plus4_s[WIDTH-1:28], jump_index, 2'b00};
  assign jr_target_s     = jr_target & ~(WIDTH'(3));

  // Priority mux; only an accepted instruction may halt or redirect.
  always_comb begin
    next_pc  = seq_pc_s;
    redirect = 1'b0;
    if (accept) begin
      if (halt) begin
        next_pc = pc;
      end else if (jr) begin
        next_pc  = jr_target_s;
        redirect = 1'b1;
      end else if (jump) begin
        next_pc  = jump_target_s;
        redirect = 1'b1;
      end else if (branch_taken) begin
        next_pc  = branch_target_s;
        redirect = 1'b1;
      end else begin
        next_pc = seq_pc_s;
      end
    end else begin
      next_pc = seq_pc_s;
    end
  end

endmodule : next_pc_sel

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, realigns the one-cycle-latency ROM
// output with id_pc, and handles redirect bubbles, stall hold and halt.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int             WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             halt,
  input  logic             branch_taken,
  input  logic [15:0]      branch_off,
  input  logic             jump,
  input  logic [25:0]      jump_index,
  input  logic             jr,
  input  logic [WIDTH-1:0] jr_target,
  input  logic [WIDTH-1:0] instruction_in,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] id_pc,
  output logic [WIDTH-1:0] id_pc_plus4,
  output logic [WIDTH-1:0] instr,
  output logic             instr_valid,
  output logic             halted,
  output logic [31:0]      instr_count
);

  fetch_state_e     state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] id_pc_q, id_pc_d;
  logic             instr_valid_q, instr_valid_d;
  logic             halted_q, halted_d;
  logic [31:0]      instr_count_q, instr_count_d;
  logic [WIDTH-1:0] instr_hold_q, instr_hold_d;
  logic             hold_flag_q, hold_flag_d;

  logic             accept_s;
  logic [WIDTH-1:0] next_pc_s;
  logic             redirect_s;

  // Decode consumes the current instruction this cycle.
  assign accept_s = (state_q == ST_RUN) && instr_valid_q && !stall;

  next_pc_sel #(
    .WIDTH(WIDTH)
  ) u_next_pc_sel (
    .accept      (accept_s),
    .halt        (halt),
    .jr          (jr),
    .jump        (jump),
    .branch_taken(branch_taken),
    .pc          (pc_q),
    .id_pc       (id_pc_q),
    .jr_target   (jr_target),
    .branch_off  (branch_off),
    .jump_index  (jump_index),
    .next_pc     (next_pc_s),
    .redirect    (redirect_s)
  );

  // FSM next state, PC pipeline, stall capture and instruction counter.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    id_pc_d       = id_pc_q;
    instr_valid_d = instr_valid_q;
    halted_d      = halted_q;
    instr_count_d = instr_count_q;
    instr_hold_d  = instr_hold_q;
    hold_flag_d   = hold_flag_q;
    case (state_q)
      ST_PRIME: begin
        pc_d          = RESET_PC + WIDTH'(PC_STEP);
        id_pc_d       = RESET_PC;
        instr_valid_d = 1'b1;
        state_d       = ST_RUN;
      end
      ST_RUN: begin
        if (instr_valid_q && stall) begin
          // Capture the word once; later ROM output belongs to pc, not id_pc.
          if (!hold_flag_q) begin
            instr_hold_d = instruction_in;
            hold_flag_d  = 1'b1;
          end else begin
            hold_flag_d  = 1'b1;
          end
        end else begin
          hold_flag_d = 1'b0;
          if (accept_s) begin
            instr_count_d = instr_count_q + 32'd1;
          end else begin
            instr_count_d = instr_count_q;
          end
          if (accept_s && halt) begin
            state_d       = ST_HALT;
            instr_valid_d = 1'b0;
            halted_d      = 1'b1;
          end else begin
            pc_d          = next_pc_s;
            id_pc_d       = pc_q;
            instr_valid_d = !redirect_s;
          end
        end
      end
      ST_HALT: begin
        instr_valid_d = 1'b0;
        halted_d      = 1'b1;
      end
      default: begin
        state_d       = ST_PRIME;
        instr_valid_d = 1'b0;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_PRIME;
      pc_q          <= RESET_PC;
      id_pc_q       <= RESET_PC;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
      instr_count_q <= 32'd0;
      instr_hold_q  <= '0;
      hold_flag_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      id_pc_q       <= id_pc_d;
      instr_valid_q <= instr_valid_d;
      halted_q      <= halted_d;
      instr_count_q <= instr_count_d;
      instr_hold_q  <= instr_hold_d;
      hold_flag_q   <= hold_flag_d;
    end
  end

  assign pc          = pc_q;
  assign id_pc       = id_pc_q;
  assign id_pc_plus4 = id_pc_q + WIDTH'(PC_STEP);
  assign instr       = hold_flag_q ? instr_hold_q : instruction_in;
  assign instr_valid = instr_valid_q;
  assign halted      = halted_q;
  assign instr_count = instr_count_q;

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a behavioural one-cycle-latency ROM.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        halt;
  logic        branch_taken;
  logic [15:0] branch_off;
  logic        jump;
  logic [25:0] jump_index;
  logic        jr;
  logic [31:0] jr_target;
  logic [31:0] instruction_in;
  logic [31:0] pc;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic [31:0] instr;
  logic        instr_valid;
  logic        halted;
  logic [31:0] instr_count;

  int checks;
  int errors;

  fetch_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .halt          (halt),
    .branch_taken  (branch_taken),
    .branch_off    (branch_off),
    .jump          (jump),
    .jump_index    (jump_index),
    .jr            (jr),
    .jr_target     (jr_target),
    .instruction_in(instruction_in),
    .pc            (pc),
    .id_pc         (id_pc),
    .id_pc_plus4   (id_pc_plus4),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .halted        (halted),
    .instr_count   (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: rom_word = 32'h2008_0005;
      32'h0000_0004: rom_word = 32'h2009_0003;
      32'h0000_0008: rom_word = 32'h0109_5020;
      default:       rom_word = 32'hE000_0000 ^ a;
    endcase
  endfunction

  // Synchronous instruction ROM, same clock as the fetch unit.
  always @(posedge clk) instruction_in <= rom_word(pc);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_fetch(input string tag, input logic [31:0] e_id, input logic [31:0] e_pc,
                           input logic e_v, input logic [31:0] e_cnt);
    chk({tag, "_id_pc"}, id_pc, e_id);
    chk({tag, "_pc"}, pc, e_pc);
    chk({tag, "_valid"}, {31'd0, instr_valid}, {31'd0, e_v});
    chk({tag, "_count"}, instr_count, e_cnt);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0; stall = 1'b0; halt = 1'b0; branch_taken = 1'b0; branch_off = 16'h0000;
    jump = 1'b0; jump_index = 26'h0; jr = 1'b0; jr_target = 32'h0;
    #2;
    chk_fetch("reset", 32'h0, 32'h0, 1'b0, 32'd0);
    chk("reset_halted", {31'd0, halted}, 32'd0);
    #10 rst_n = 1'b1;  // t=12, between edges
    chk_fetch("prime", 32'h0, 32'h0, 1'b0, 32'd0);

    // Sequential start-up
    tick(); chk_fetch("seq0", 32'h0, 32'h4, 1'b1, 32'd0); chk("seq0_instr", instr, 32'h2008_0005);
    tick(); chk_fetch("seq1", 32'h4, 32'h8, 1'b1, 32'd1); chk("seq1_instr", instr, 32'h2009_0003);
    tick(); chk_fetch("seq2", 32'h8, 32'hC, 1'b1, 32'd2); chk("seq2_instr", instr, 32'h0109_5020);
    chk("seq2_plus4", id_pc_plus4, 32'hC);

    // Backward branch at id_pc=8: target 8+4-8=4
    branch_taken = 1'b1; branch_off = 16'hFFFE;
    tick(); chk_fetch("br_bub", 32'hC, 32'h4, 1'b0, 32'd3);
    branch_taken = 1'b0;
    tick(); chk_fetch("br_tgt", 32'h4, 32'h8, 1'b1, 32'd3); chk("br_tgt_instr", instr, 32'h2009_0003);
    tick(); tick(); chk_fetch("pre_j", 32'hC, 32'h10, 1'b1, 32'd5);

    // Jump at id_pc=0xC, index 0x10 -> 0x40
    jump = 1'b1; jump_index = 26'h10;
    tick(); chk_fetch("j_bub", 32'h10, 32'h40, 1'b0, 32'd6);
    jump = 1'b0;
    tick(); chk_fetch("j_tgt", 32'h40, 32'h44, 1'b1, 32'd6); chk("j_instr", instr, 32'hE000_0040);

    // jr 0x23 -> 0x20 (low bits cleared)
    jr = 1'b1; jr_target = 32'h0000_0023;
    tick(); chk_fetch("jr_bub", 32'h44, 32'h20, 1'b0, 32'd7);
    jr = 1'b0;
    tick(); chk_fetch("jr_tgt", 32'h20, 32'h24, 1'b1, 32'd7); chk("jr_instr", instr, 32'hE000_0020);

    // jr back to 0xC so that the stall lands on id_pc=0x10
    jr = 1'b1; jr_target = 32'h0000_000E;
    tick(); jr = 1'b0;
    tick(); chk_fetch("jr2_tgt", 32'hC, 32'h10, 1'b1, 32'd8);
    tick(); chk_fetch("pre_st", 32'h10, 32'h14, 1'b1, 32'd9);

    // Stall three cycles at id_pc=0x10
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_fetch($sformatf("stall%0d", i), 32'h10, 32'h14, 1'b1, 32'd9);
      chk($sformatf("stall%0d_instr", i), instr, 32'hE000_0010);
    end
    stall = 1'b0;
    tick(); chk_fetch("st_rel", 32'h14, 32'h18, 1'b1, 32'd10); chk("st_rel_instr", instr, 32'hE000_0014);

    // Stall with branch for 2 cycles, then branch alone: +4+16 -> 0x28
    stall = 1'b1; branch_taken = 1'b1; branch_off = 16'h0004;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_fetch($sformatf("stbr%0d", i), 32'h14, 32'h18, 1'b1, 32'd10);
      chk($sformatf("stbr%0d_instr", i), instr, 32'hE000_0014);
    end
    stall = 1'b0;
    tick(); chk_fetch("stbr_bub", 32'h18, 32'h28, 1'b0, 32'd11);
    branch_taken = 1'b0;
    tick(); chk_fetch("stbr_tgt", 32'h28, 32'h2C, 1'b1, 32'd11); chk("stbr_instr", instr, 32'hE000_0028);

    // Squashed cycle ignores halt/redirect; return to 0x18
    jr = 1'b1; jr_target = 32'h0000_0018;
    tick(); jr = 1'b0; halt = 1'b1; branch_taken = 1'b1;
    tick(); halt = 1'b0; branch_taken = 1'b0;
    chk_fetch("sq_ign", 32'h18, 32'h1C, 1'b1, 32'd12); chk("sq_instr", instr, 32'hE000_0018);

    // Halt at id_pc=0x18
    halt = 1'b1;
    tick(); chk_fetch("halt", 32'h18, 32'h1C, 1'b0, 32'd13); chk("halt_flag", {31'd0, halted}, 32'd1);
    jump = 1'b1; jump_index = 26'h3;
    tick(); tick(); chk_fetch("halt_frz", 32'h18, 32'h1C, 1'b0, 32'd13);
    chk("halt_frz_flag", {31'd0, halted}, 32'd1);
    halt = 1'b0; jump = 1'b0;

    // Asynchronous reset mid-cycle
    #2 rst_n = 1'b0;
    #1;
    chk_fetch("arst", 32'h0, 32'h0, 1'b0, 32'd0); chk("arst_halted", {31'd0, halted}, 32'd0);
    #3 rst_n = 1'b1;
    tick(); chk_fetch("re_prime", 32'h0, 32'h4, 1'b1, 32'd0); chk("re_instr", instr, 32'h2008_0005);

    // PC wrap: jr to 0xFFFF_FFFC, next fetch address wraps to 0
    jr = 1'b1; jr_target = 32'hFFFF_FFFF;
    tick(); jr = 1'b0; chk_fetch("wr_bub", 32'h4, 32'hFFFF_FFFC, 1'b0, 32'd1);
    tick(); chk_fetch("wrap", 32'hFFFF_FFFC, 32'h0, 1'b1, 32'd1);
    chk("wrap_plus4", id_pc_plus4, 32'h0);
    tick(); chk_fetch("wrap2", 32'h0, 32'h4, 1'b1, 32'd2); chk("wrap2_instr", instr, 32'h2008_0005);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_fetch_unit

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the single-cycle MIPS CPU. It sits directly upstream of the memory block.
- It owns the PC register and drives the instruction-memory address.
- It realigns the synchronous (one-cycle-latency) instruction ROM output with the PC of the instruction being decoded.
- It handles branch, jump, jr, stall and halt, and presents a valid-qualified instruction to decode.

Parameters:
- WIDTH, 32, datapath and PC width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  single system clock; the memory block's ROM read clock is the same clock.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  decode/execute hold request.
- halt  in  1  decoded halt instruction.
- branch_taken  in  1  conditional branch resolved taken.
- branch_off  in  16  branch immediate, word offset.
- jump  in  1  j/jal.
- jump_index  in  26  jump target index.
- jr  in  1  register jump.
- jr_target  in  WIDTH  register jump target.
- instruction_in  in  WIDTH  instruction-memory read data.
- pc  out  WIDTH  fetch address to instruction memory.
- id_pc  out  WIDTH  PC of the instruction on instr.
- id_pc_plus4  out  WIDTH  id_pc+4, used for jal link.
- instr  out  WIDTH  instruction to decode.
- instr_valid  out  1  instr is a real, unsquashed instruction.
- halted  out  1  CPU is in HALT state.
- instr_count  out  32  number of instructions accepted by decode.

Behaviour:
- Interface: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: pc=RESET_PC, id_pc=RESET_PC, instr_valid=0, halted=0, instr_count=0, hold register=0, state=PRIME.
- States: PRIME, RUN, HALT.
- PRIME: lasts one edge. At that edge: pc<=RESET_PC+4, id_pc<=RESET_PC, instr_valid<=1, go to RUN.
- ROM alignment: instruction_in at any cycle is ROM(pc sampled at the previous edge). On every advancing edge the unit sets id_pc<=pc, so instruction_in always corresponds to id_pc.
- RUN, "accepted" condition: instr_valid=1 and stall=0. Only an accepted instruction may redirect, halt, or increment instr_count (+1, wrapping mod 2^32).
- Next-PC priority (accepted instruction only): halt > jr > jump > branch_taken > sequential.
  - sequential: pc<=pc+4, id_pc<=pc, instr_valid<=1.
  - branch target: id_pc+4+(sext(branch_off)<<2).
  - jump target: {id_pc_plus4[31:28], jump_index, 2'b00}.
  - jr target: jr_target, with bits [1:0] forced to 0.
- Redirect (any of jr/jump/branch_taken):
  - Edge 1: pc<=target, id_pc<=pc (wrong path), instr_valid<=0.
  - Edge 2: pc<=target+4, id_pc<=target, instr_valid<=1.
  - Exactly one bubble per redirect.
- Squashed cycle (instr_valid=0 in RUN): redirect, halt and stall inputs are ignored; the unit advances sequentially.
- Stall: applies only while instr_valid=1.
  - pc, id_pc and instr_valid hold.
  - On the first stall cycle, instr_hold<=instruction_in and hold flag<=1.
  - instr = hold flag ? instr_hold : instruction_in.
  - On the edge where stall drops, the flag clears. No instruction is lost or duplicated.
  - Simultaneous stall and redirect/halt: stall wins. Decode must keep the request asserted until stall drops.
- HALT: entered at the edge that accepts halt.
  - instr_valid<=0, halted<=1.
  - pc and id_pc frozen; instr_count frozen.
  - Only rst_n exits HALT.
- Arithmetic: all PC arithmetic is mod 2^WIDTH. 32'hFFFF_FFFC+4 wraps to 0. Memory aliasing of high PC bits is the memory's concern, not this block's.
- Reset mid-operation: asynchronous return to reset values from any state, including mid-stall (hold flag cleared) and during the redirect bubble.
- id_pc_plus4 is combinational id_pc+4. All other outputs are registered, except instr, which is a mux of instruction_in and instr_hold.

Decomposition:
- Shared package: state encoding (PRIME/RUN/HALT) and the constant PC_STEP=4.
- One sub-module, next_pc_sel: a combinational target computation plus priority mux, with inputs id_pc, redirect controls and pc. The FSM, stall hold register and counters stay in fetch_unit.

Test Plan:
- Reset release with ROM words 0x20080005, 0x20090003, 0x01095020 at 0/4/8: instr_valid=0 in the first cycle, then instr sequence matches with id_pc 0,4,8 and instr_count 1,2,3.
- branch_taken=1 with branch_off=16'hFFFE at id_pc=8: next cycle instr_valid=0; the following cycle id_pc=4 (8+4-8) and instr_valid=1.
- jump with jump_index=26'h10 at id_pc=0x0C, then jr with jr_target=0x0000_0023 later: id_pc becomes 0x40 then 0x20, one bubble each.
- stall held 3 cycles at id_pc=0x10: instr/id_pc stable for all 3 cycles; after release id_pc=0x14 with the correct word and instr_count+1 only once.
- stall and branch_taken together for 2 cycles, then branch_taken alone: redirect occurs only after stall drops.
- halt at id_pc=0x18, then rst_n pulsed low asynchronously mid-cycle: halted=1, pc frozen at 0x1C, instr_valid=0; after reset pc=RESET_PC, halted=0, instr_count=0.
